// File: rtl/asyn_counter.sv
// asyn_counter: modulo-MODULUS ripple (asynchronous) up-counter built from
// toggle stages.
//
// Stage 0 toggles on the rising edge of clk while en is high. Each later
// stage toggles on the falling edge of the stage below it. When the stages
// reach a value >= MODULUS, a decode clears all stages asynchronously, so
// the counter wraps to 0.
//
// Build option: ASYN_COUNTER_SYNC_OUT_EN
//   defined   - count/tc come from a clk-rising-edge register that samples
//               the settled ripple value. The outputs are glitch-free and
//               lag the ripple value by one cycle.
//   undefined - count/tc are driven straight from the ripple stages, so the
//               brief wrap transient can be visible on count.
//
// Parameters:
//   MODULUS  count sequence length, 2..2**WIDTH
//   WIDTH    count width, 2**WIDTH >= MODULUS
// Ports:
//   clk      clock; its rising edge drives stage 0
//   reset    asynchronous active-low reset; clears all state immediately
//   en       count enable, sampled at the rising edge of clk
//   count    current count value, 0..MODULUS-1
//   tc       terminal count: high while count == MODULUS-1 and en == 1

module asyn_counter #(
  parameter int unsigned MODULUS = 12,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] ripple;
  logic             wrap;
  logic             clr_n;
  logic             at_last;

  // A ripple increment only clears low-order bits until the final set bit
  // lands. Every intermediate value is therefore below the old value, and
  // the >= decode fires only on a genuine overflow or on a stray illegal state.
  assign wrap    = (32'(ripple) >= MODULUS);
  assign clr_n   = reset & ~wrap;
  assign at_last = (32'(ripple) == (MODULUS - 1));

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic q;

    if (i == 0) begin : g_first
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          q <= 1'b0;
        end else if (en) begin
          q <= ~q;
        end
      end
    end else begin : g_next
      logic ck;

      // The stage clock is gated by clr_n. A lower stage that drops to 0
      // because of the clear therefore produces no carry edge once the
      // clear is released. Only real carries advance this stage.
      assign ck = ripple[i-1] & clr_n;

      always_ff @(negedge ck or negedge clr_n) begin
        if (!clr_n) begin
          q <= 1'b0;
        end else begin
          q <= ~q;
        end
      end
    end

    assign ripple[i] = q;
  end

`ifdef ASYN_COUNTER_SYNC_OUT_EN
  logic [WIDTH-1:0] count_q;
  logic             tc_q;

  // Stage 0 changes with the same edge, so this register captures the
  // value the ripple chain settled to during the previous cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= ripple;
      tc_q    <= at_last & en;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
`else
  assign count = ripple;
  assign tc    = at_last & en;
`endif

endmodule

// File: tb/tb_asyn_counter.sv
// Self-checking bench for asyn_counter. It runs a default instance
// (MODULUS 12) and a MODULUS 10 instance from the same clock, reset and
// enable. A bench-side model counts enabled edges modulo MODULUS. A negedge
// compare process checks both instances against that model on every cycle.
// Directed phases with literal expectations pin the model itself.

module tb_asyn_counter;

  localparam int unsigned M_A = 12;
  localparam int unsigned M_B = 10;
`ifdef ASYN_COUNTER_SYNC_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [3:0] count_a;
  logic [3:0] count_b;
  logic       tc_a;
  logic       tc_b;

  int vectors     = 0;
  int miscompares = 0;
  bit check_on    = 1'b0;

  // Model state: m_* is the number of enabled edges modulo MODULUS since
  // reset. *_out and *_tc hold the view of that count one edge later.
  int unsigned m_a    = 0;
  int unsigned m_b    = 0;
  int unsigned ma_out = 0;
  int unsigned mb_out = 0;
  bit          ma_tc  = 1'b0;
  bit          mb_tc  = 1'b0;

  always #5 clk = ~clk;

  asyn_counter #(.MODULUS(M_A), .WIDTH(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .count (count_a),
    .tc    (tc_a)
  );

  asyn_counter #(.MODULUS(M_B), .WIDTH(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .count (count_b),
    .tc    (tc_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #6;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a    = 0;
      m_b    = 0;
      ma_out = 0;
      mb_out = 0;
      ma_tc  = 1'b0;
      mb_tc  = 1'b0;
    end else begin
      ma_out = m_a;
      mb_out = m_b;
      ma_tc  = (m_a == M_A - 1) && en;
      mb_tc  = (m_b == M_B - 1) && en;
      if (en) begin
        m_a = (m_a + 1) % M_A;
        m_b = (m_b + 1) % M_B;
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
`ifdef ASYN_COUNTER_SYNC_OUT_EN
      chk("model count m12", 32'(count_a), ma_out);
      chk("model tc m12",    32'(tc_a),    32'(ma_tc));
      chk("model count m10", 32'(count_b), mb_out);
      chk("model tc m10",    32'(tc_b),    32'(mb_tc));
`else
      chk("model count m12", 32'(count_a), m_a);
      chk("model tc m12",    32'(tc_a),    32'((m_a == M_A - 1) && en));
      chk("model count m10", 32'(count_b), m_b);
      chk("model tc m10",    32'(tc_b),    32'((m_b == M_B - 1) && en));
`endif
    end
  end

`ifdef ASYN_COUNTER_SYNC_OUT_EN
  bit glitch_a = 1'b0;
  bit glitch_b = 1'b0;
  always @(count_a) if (count_a >= 4'(M_A)) glitch_a = 1'b1;
  always @(count_b) if (count_b >= 4'(M_B)) glitch_b = 1'b1;
`endif

  initial begin
    #1;
    reset = 1'b0;
    en    = 1'b1;
    #1;
    check_on = 1'b1;

    // Reset held for about 100 ns with en high.
    repeat (10) begin
      step();
      chk("reset count", 32'(count_a), 32'd0);
      chk("reset tc",    32'(tc_a),    32'd0);
    end

    // Count and wrap over 14 edges.
    reset = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("wrap m12 count", 32'(count_a), 32'((k - LAT) % 12));
      chk("wrap m12 tc",    32'(tc_a),    32'(((k - LAT) % 12) == 11));
      chk("wrap m10 count", 32'(count_b), 32'((k - LAT) % 10));
      chk("wrap m10 tc",    32'(tc_b),    32'(((k - LAT) % 10) == 9));
    end
    chk("wrap m12 final", 32'(count_a), (LAT == 1) ? 32'd1 : 32'd2);

    // Mid-run reset: a 10 ns low pulse that spans a rising edge.
    #2 reset = 1'b0;
    #5;
    chk("midreset count", 32'(count_a), 32'd0);
    chk("midreset tc",    32'(tc_a),    32'd0);
    #5 reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("restart count", 32'(count_a), 32'(k - LAT));
    end

    // Hold at 5 for six edges, then resume.
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("hold count", 32'(count_a), 32'd5);
      chk("hold tc",    32'(tc_a),    32'd0);
    end
    en = 1'b1;
    repeat (LAT) step();
    step();
    chk("resume count", 32'(count_a), 32'd6);

    // Several more wraps of both instances under the per-cycle compare.
    repeat (40) step();

`ifdef ASYN_COUNTER_SYNC_OUT_EN
    chk("no transient m12", 32'(glitch_a), 32'd0);
    chk("no transient m10", 32'(glitch_b), 32'd0);
`endif

    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
